// File: rtl/his_peak_reader_pkg.sv
// Shared types and constants for the histogram peak reader.
package his_peak_reader_pkg;

    localparam int unsigned DEF_RAM_ADDR = 10;
    localparam int unsigned DEF_PEAK_MAX = 16;
    localparam int unsigned DEF_BIN_NUM  = 64;

    // RAM port polarities: port b read enable is active low, port a write enable active high
    localparam logic RD_EN = 1'b0;
    localparam logic WR_EN = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/his_peak_reader_if.sv
// Dual-port histogram RAM bus: port b read path and port a clear path.
interface his_peak_reader_if #(
    parameter int unsigned RAM_ADDR = 10,
    parameter int unsigned PEAK_MAX = 16
);
    logic [RAM_ADDR-1:0] raddr;
    logic                rEnable;
    logic                readFlag;
    logic [PEAK_MAX-1:0] counts;
    logic [RAM_ADDR-1:0] waddr;
    logic                wEnable;
    logic                writeFlag;
    logic [PEAK_MAX-1:0] newCounts;

    modport master (
        output raddr, rEnable, readFlag,
        output waddr, wEnable, writeFlag, newCounts,
        input  counts
    );

    modport slave (
        input  raddr, rEnable, readFlag,
        input  waddr, wEnable, writeFlag, newCounts,
        output counts
    );
endinterface

// File: rtl/his_peak_reader_max_tracker.sv
// Running max / argmax tracker with synchronous clear; strict greater-than,
// so on equal values the earliest (lowest index) entry is kept.
// max_val/max_idx include the compare of the current cycle, which lets a
// caller capture the final result on the same edge as the last compare.
module his_max_tracker #(
    parameter int unsigned VAL_W = 16,
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [VAL_W-1:0] value,
    input  logic [IDX_W-1:0] idx,
    output logic [VAL_W-1:0] max_val,
    output logic [IDX_W-1:0] max_idx
);

    logic [VAL_W-1:0] run_max;
    logic [IDX_W-1:0] run_idx;

    // next running values: clear, or take a strictly larger sample
    always_comb begin
        max_val = run_max;
        max_idx = run_idx;
        if (clr) begin
            max_val = '0;
            max_idx = '0;
        end else if (en && (value > run_max)) begin
            max_val = value;
            max_idx = idx;
        end
    end

    // hold the running max/argmax
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max <= '0;
            run_idx <= '0;
        end else begin
            run_max <= max_val;
            run_idx <= max_idx;
        end
    end

endmodule

// File: rtl/his_peak_reader.sv
// Histogram peak reader: scans BIN_NUM bins of one pixel through RAM port b
// and reports the peak bin index and count.
// Optional feature macro: CLEAR_AFTER_READ_EN (zero each bin via port a
// one cycle after it is read).
module his_peak_reader
    import his_peak_reader_pkg::*;
#(
    parameter int unsigned RAM_ADDR = DEF_RAM_ADDR,
    parameter int unsigned PEAK_MAX = DEF_PEAK_MAX,
    parameter int unsigned BIN_NUM  = DEF_BIN_NUM,
    parameter int unsigned BIN_W    = $clog2(BIN_NUM)
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic [RAM_ADDR-1:0] baseAddr,
    his_peak_reader_if.master   ram,
    output logic                busy,
    output logic                done,
    output logic [BIN_W-1:0]    peakBin,
    output logic [PEAK_MAX-1:0] peakCount,
    output logic                peakValid
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_NUM - 1);

    state_t              state;
    logic [RAM_ADDR-1:0] raddr_q;
    logic                rd_en_q;
    logic                rd_flag_q;
    logic [BIN_W-1:0]    rd_bin;

    // read issued last cycle; its data is on counts this cycle
    logic                cmp_en;
    logic [BIN_W-1:0]    cmp_bin;

    logic                clr_run;
    logic [PEAK_MAX-1:0] max_val;
    logic [BIN_W-1:0]    max_idx;

    assign clr_run = (state == S_IDLE) && start;

    his_max_tracker #(
        .VAL_W(PEAK_MAX),
        .IDX_W(BIN_W)
    ) u_max (
        .clk    (clk),
        .rst_n  (res),
        .clr    (clr_run),
        .en     (cmp_en),
        .value  (ram.counts),
        .idx    (cmp_bin),
        .max_val(max_val),
        .max_idx(max_idx)
    );

    // scan FSM with registered RAM read controls and results
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= S_IDLE;
            raddr_q   <= '0;
            rd_en_q   <= ~RD_EN;
            rd_flag_q <= 1'b0;
            rd_bin    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            peakBin   <= '0;
            peakCount <= '0;
            peakValid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_READ;
                        busy      <= 1'b1;
                        raddr_q   <= baseAddr;
                        rd_bin    <= '0;
                        rd_en_q   <= RD_EN;
                        rd_flag_q <= 1'b1;
                    end
                end
                S_READ: begin
                    if (rd_bin == LAST_BIN) begin
                        state     <= S_DRAIN;
                        rd_en_q   <= ~RD_EN;
                        rd_flag_q <= 1'b0;
                    end else begin
                        rd_bin  <= rd_bin + BIN_W'(1);
                        raddr_q <= raddr_q + RAM_ADDR'(1);
                    end
                end
                S_DRAIN: begin
                    // last word is compared this cycle; capture the tracker's
                    // post-compare value so results are valid with done
                    state     <= S_DONE;
                    done      <= 1'b1;
                    peakBin   <= max_idx;
                    peakCount <= max_val;
                    peakValid <= (max_val != '0);
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // delay the issued read's bin index to line up with counts
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cmp_en  <= 1'b0;
            cmp_bin <= '0;
        end else begin
            cmp_en  <= rd_flag_q;
            cmp_bin <= rd_bin;
        end
    end

    assign ram.raddr    = raddr_q;
    assign ram.rEnable  = rd_en_q;
    assign ram.readFlag = rd_flag_q;

`ifdef CLEAR_AFTER_READ_EN
    logic [RAM_ADDR-1:0] cmp_addr;

    // delay the issued read address to clear the bin just read
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cmp_addr <= '0;
        end else begin
            cmp_addr <= raddr_q;
        end
    end

    assign ram.waddr     = cmp_en ? cmp_addr : '0;
    assign ram.wEnable   = cmp_en ? WR_EN : ~WR_EN;
    assign ram.writeFlag = cmp_en;
    assign ram.newCounts = '0;
`else
    assign ram.waddr     = '0;
    assign ram.wEnable   = ~WR_EN;
    assign ram.writeFlag = 1'b0;
    assign ram.newCounts = '0;
`endif

endmodule

// File: tb/tb_his_peak_reader.sv
// Self-checking bench for his_peak_reader (BIN_NUM=8, RAM_ADDR=10).
module tb_his_peak_reader;

    localparam int unsigned RAM_ADDR = 10;
    localparam int unsigned PEAK_MAX = 16;
    localparam int unsigned BIN_NUM  = 8;
    localparam int unsigned BIN_W    = 3;
    localparam int unsigned DEPTH    = 1 << RAM_ADDR;
    localparam int unsigned LAT      = BIN_NUM + 2;

    logic                clk = 1'b0;
    logic                res = 1'b0;
    logic                start = 1'b0;
    logic [RAM_ADDR-1:0] baseAddr = '0;
    logic                busy;
    logic                done;
    logic [BIN_W-1:0]    peakBin;
    logic [PEAK_MAX-1:0] peakCount;
    logic                peakValid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // results the bench believes the DUT currently holds
    int prev_bin = 0;
    int prev_cnt = 0;
    int prev_val = 0;

    his_peak_reader_if #(.RAM_ADDR(RAM_ADDR), .PEAK_MAX(PEAK_MAX)) ram_bus ();

    his_peak_reader #(
        .RAM_ADDR(RAM_ADDR),
        .PEAK_MAX(PEAK_MAX),
        .BIN_NUM (BIN_NUM),
        .BIN_W   (BIN_W)
    ) dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .baseAddr (baseAddr),
        .ram      (ram_bus),
        .busy     (busy),
        .done     (done),
        .peakBin  (peakBin),
        .peakCount(peakCount),
        .peakValid(peakValid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dual-port RAM: 1-cycle registered read on port b, write on port a
    logic [PEAK_MAX-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_bus.writeFlag && ram_bus.wEnable) mem[ram_bus.waddr] <= ram_bus.newCounts;
        if (ram_bus.readFlag && !ram_bus.rEnable) ram_bus.counts <= mem[ram_bus.raddr];
    end

    // bus activity log
    int rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$], wr_cyc_q[$], wr_data_q[$], done_cyc_q[$];
    int pol_bad = 0;
    always @(negedge clk) begin
        if (ram_bus.readFlag == ram_bus.rEnable && res) pol_bad <= pol_bad + 1;
        if (!ram_bus.rEnable) begin
            rd_addr_q.push_back(int'(ram_bus.raddr));
            rd_cyc_q.push_back(cyc);
        end
        if (ram_bus.wEnable || ram_bus.writeFlag) begin
            wr_addr_q.push_back(int'(ram_bus.waddr));
            wr_cyc_q.push_back(cyc);
            wr_data_q.push_back(int'(ram_bus.newCounts));
        end
        if (done) done_cyc_q.push_back(cyc);
    end

    task automatic clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete();
        wr_addr_q.delete(); wr_cyc_q.delete(); wr_data_q.delete();
        done_cyc_q.delete();
        pol_bad = 0;
    endtask

    // reference: peak of BIN_NUM bins starting at base, lowest bin wins ties
    task automatic ref_peak(input int base, output int rbin, output int rcnt);
        rbin = 0;
        rcnt = 0;
        for (int i = 0; i < int'(BIN_NUM); i++) begin
            if (int'(mem[(base + i) % DEPTH]) > rcnt) begin
                rcnt = int'(mem[(base + i) % DEPTH]);
                rbin = i;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        logic [63:0] got;
        logic [63:0] want;
        got  = {busy, done, peakValid, ram_bus.rEnable, ram_bus.readFlag, ram_bus.wEnable,
                ram_bus.writeFlag, 1'b0, 5'd0, peakBin, peakCount, 6'd0, ram_bus.raddr,
                6'd0, ram_bus.waddr};
        want = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 16'd0,
                6'd0, 10'd0, 6'd0, 10'd0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s reset_outputs: got %h expected %h", tag, got, want);
        end
        checks++;
        if (ram_bus.newCounts !== '0) begin
            errors++;
            $display("FAIL %s reset_newCounts: got %h expected 0", tag, ram_bus.newCounts);
        end
    endtask

    // one full scan at base with timing, address, result and clear checks
    task automatic do_scan(input int base, input string tag);
        logic [PEAK_MAX-1:0] snap [BIN_NUM];
        int  exp_bin, exp_cnt, t, dcyc, busy_bad;
        bit  seen;
        for (int i = 0; i < int'(BIN_NUM); i++) snap[i] = mem[(base + i) % DEPTH];
        ref_peak(base, exp_bin, exp_cnt);
        clear_logs();
        @(negedge clk);
        start    = 1'b1;
        baseAddr = RAM_ADDR'(base);
        t        = cyc;
        @(negedge clk);
        start    = 1'b0;
        baseAddr = RAM_ADDR'($urandom);
        seen     = 1'b0;
        dcyc     = 0;
        busy_bad = 0;
        for (int k = 0; k < int'(LAT) + 6 && !seen; k++) begin
            if (cyc == t + 5) begin
                checks++;
                if (peakCount !== PEAK_MAX'(prev_cnt) || peakBin !== BIN_W'(prev_bin)
                    || peakValid !== 1'(prev_val)) begin
                    errors++;
                    $display("FAIL %s held_results: got bin %0d cnt %0d val %0d expected bin %0d cnt %0d val %0d",
                             tag, peakBin, peakCount, peakValid, prev_bin, prev_cnt, prev_val);
                end
            end
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles, expected at %0d", tag, LAT + 6, LAT);
            return;
        end
        if (dcyc - t != int'(LAT)) begin
            errors++;
            $display("FAIL %s done_latency: got %0d expected %0d", tag, dcyc - t, LAT);
        end
        checks++;
        if (peakBin !== BIN_W'(exp_bin) || peakCount !== PEAK_MAX'(exp_cnt)
            || peakValid !== (exp_cnt != 0)) begin
            errors++;
            $display("FAIL %s peak: got bin %0d cnt %0d val %0d expected bin %0d cnt %0d val %0d",
                     tag, peakBin, peakCount, peakValid, exp_bin, exp_cnt, exp_cnt != 0);
        end
        prev_bin = exp_bin;
        prev_cnt = exp_cnt;
        prev_val = (exp_cnt != 0) ? 1 : 0;
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_during_scan: low for %0d cycles, expected 0", tag, busy_bad);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done %b busy %b expected 0 0", tag, done, busy);
        end
        @(negedge clk);
        checks++;
        if (rd_addr_q.size() != int'(BIN_NUM) || pol_bad != 0) begin
            errors++;
            $display("FAIL %s read_count: got %0d reads, %0d polarity errors expected %0d, 0",
                     tag, rd_addr_q.size(), pol_bad, BIN_NUM);
        end else begin
            for (int i = 0; i < int'(BIN_NUM); i++) begin
                checks++;
                if (rd_addr_q[i] != (base + i) % int'(DEPTH) || rd_cyc_q[i] != t + 1 + i) begin
                    errors++;
                    $display("FAIL %s read_%0d: got addr %0d at +%0d expected addr %0d at +%0d",
                             tag, i, rd_addr_q[i], rd_cyc_q[i] - t, (base + i) % int'(DEPTH), 1 + i);
                end
            end
        end
`ifdef CLEAR_AFTER_READ_EN
        checks++;
        if (wr_addr_q.size() != int'(BIN_NUM)) begin
            errors++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, wr_addr_q.size(), BIN_NUM);
        end else begin
            for (int i = 0; i < int'(BIN_NUM); i++) begin
                checks++;
                if (wr_addr_q[i] != (base + i) % int'(DEPTH) || wr_cyc_q[i] != t + 2 + i
                    || wr_data_q[i] != 0) begin
                    errors++;
                    $display("FAIL %s write_%0d: got addr %0d at +%0d data %0d expected addr %0d at +%0d data 0",
                             tag, i, wr_addr_q[i], wr_cyc_q[i] - t, wr_data_q[i], (base + i) % int'(DEPTH), 2 + i);
                end
            end
        end
        for (int i = 0; i < int'(BIN_NUM); i++) begin
            checks++;
            if (mem[(base + i) % DEPTH] !== '0) begin
                errors++;
                $display("FAIL %s cleared_%0d: got %0d expected 0", tag, i, mem[(base + i) % DEPTH]);
            end
        end
`else
        checks++;
        if (wr_addr_q.size() != 0) begin
            errors++;
            $display("FAIL %s port_a_idle: got %0d active cycles expected 0", tag, wr_addr_q.size());
        end
        for (int i = 0; i < int'(BIN_NUM); i++) begin
            checks++;
            if (mem[(base + i) % DEPTH] !== snap[i]) begin
                errors++;
                $display("FAIL %s untouched_%0d: got %0d expected %0d", tag, i, mem[(base + i) % DEPTH], snap[i]);
            end
        end
`endif
    endtask

    task automatic test_reset();
        res = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        res = 1'b1;
        @(negedge clk);
        check_reset_vals("post_release");
    endtask

    task automatic test_spec_vector();
        logic [PEAK_MAX-1:0] v [BIN_NUM] = '{3, 9, 2, 9, 0, 1, 5, 4};
        for (int i = 0; i < int'(BIN_NUM); i++) mem[i] = v[i];
        do_scan(0, "spec_vector");
`ifdef CLEAR_AFTER_READ_EN
        do_scan(0, "rescan_cleared");
`endif
    endtask

    task automatic test_all_zero();
        for (int i = 0; i < int'(BIN_NUM); i++) mem[200 + i] = '0;
        do_scan(200, "all_zero");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < int'(BIN_NUM); i++) mem[(1020 + i) % DEPTH] = PEAK_MAX'($urandom_range(0, 16'hFFFE));
        mem[2] = 16'hFFFF;
        do_scan(1020, "wrap");
    endtask

    task automatic test_random();
        int base;
        for (int n = 0; n < 6; n++) begin
            base = int'($urandom_range(0, DEPTH - 1));
            for (int i = 0; i < int'(BIN_NUM); i++) begin
                if (n % 2 == 0) mem[(base + i) % DEPTH] = PEAK_MAX'($urandom_range(0, 3));
                else            mem[(base + i) % DEPTH] = PEAK_MAX'($urandom);
            end
            do_scan(base, $sformatf("random_%0d", n));
        end
    endtask

    task automatic test_back_to_back();
        int base, exp_bin, exp_cnt, t, ndone, low_cnt;
        int dc [3];
        base = 512;
        for (int i = 0; i < int'(BIN_NUM); i++) mem[base + i] = PEAK_MAX'($urandom_range(1, 1000));
        ref_peak(base, exp_bin, exp_cnt);
        @(negedge clk);
        start    = 1'b1;
        baseAddr = RAM_ADDR'(base);
        t        = cyc;
        ndone    = 0;
        low_cnt  = 0;
        for (int k = 0; k < 50 && ndone < 3; k++) begin
            @(negedge clk);
            if (ndone > 0 && busy === 1'b0) low_cnt++;
            if (done === 1'b1) begin
                dc[ndone] = cyc;
                checks++;
                if (peakBin !== BIN_W'(exp_bin) || peakCount !== PEAK_MAX'(exp_cnt)) begin
                    errors++;
                    $display("FAIL b2b_peak_%0d: got bin %0d cnt %0d expected bin %0d cnt %0d",
                             ndone, peakBin, peakCount, exp_bin, exp_cnt);
                end
`ifdef CLEAR_AFTER_READ_EN
                exp_bin = 0;
                exp_cnt = 0;
`endif
                ndone++;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 3) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d done pulses expected 3", ndone);
        end else begin
            if (dc[0] - t != int'(LAT) || dc[1] - dc[0] != int'(LAT) + 1 || dc[2] - dc[1] != int'(LAT) + 1) begin
                errors++;
                $display("FAIL b2b_spacing: got +%0d, %0d, %0d expected +%0d, %0d, %0d",
                         dc[0] - t, dc[1] - dc[0], dc[2] - dc[1], LAT, LAT + 1, LAT + 1);
            end
            checks++;
            if (low_cnt != 2) begin
                errors++;
                $display("FAIL b2b_busy_gap: got %0d low cycles expected 2", low_cnt);
            end
        end
        prev_bin = exp_bin;
        prev_cnt = exp_cnt;
        prev_val = (exp_cnt != 0) ? 1 : 0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = 300;
        for (int i = 0; i < int'(BIN_NUM); i++) mem[base + i] = PEAK_MAX'($urandom_range(1, 60000));
        clear_logs();
        @(negedge clk);
        start    = 1'b1;
        baseAddr = RAM_ADDR'(base);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_scan_reset");
        @(negedge clk);
        res = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (done_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d done pulses expected 0", done_cyc_q.size());
        end
        prev_bin = 0;
        prev_cnt = 0;
        prev_val = 0;
        for (int i = 0; i < int'(BIN_NUM); i++) mem[base + i] = PEAK_MAX'($urandom_range(1, 60000));
        do_scan(base, "after_mid_reset");
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        test_reset();
        test_spec_vector();
        test_all_zero();
        test_wrap();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
